// File: rtl/input_router_pkg.sv
// Shared router definitions: ingress FSM states, header field layout, default widths.
// Combinational definitions only; no latency or backpressure of its own.
package yas_router_pkg;

  typedef enum logic [1:0] {HDR, PAY, DROP} state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DEST_W    = 2;
  localparam int DEF_LEN_W     = 4;
  localparam int STATS_W       = 16;

  // Header layout: destination in the low bits, payload length directly above it.
  localparam int DEST_LSB = 0;

  function automatic int len_lsb(input int dest_w);
    return DEST_LSB + dest_w;
  endfunction

  localparam int LEN_LSB = len_lsb(DEF_DEST_W);

endpackage

// File: rtl/input_router_if.sv
// Ingress req/ack word stream plus per-port FIFO push bus of one router input.
// Master side is the upstream source and FIFOs; slave side is the router.
interface input_router_if #(
  parameter int DATA_W    = yas_router_pkg::DEF_DATA_W,
  parameter int NUM_PORTS = yas_router_pkg::DEF_NUM_PORTS
);
  logic [DATA_W-1:0]    data_in;
  logic                 data_in_req;
  logic                 data_in_ack;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_push;
  logic [DATA_W-1:0]    fifo_data;

  modport master (
    output data_in, data_in_req, fifo_full,
    input  data_in_ack, fifo_push, fifo_data
  );

  modport slave (
    input  data_in, data_in_req, fifo_full,
    output data_in_ack, fifo_push, fifo_data
  );
endinterface

// File: rtl/input_router_hdr_decode.sv
// Header word -> destination, payload length and destination-valid flag.
// Purely combinational, zero latency, no backpressure.
module hdr_decode
  import yas_router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DEST_W    = DEF_DEST_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic [DATA_W-1:0] hdr,
  output logic [DEST_W-1:0] dest,
  output logic [LEN_W-1:0]  len,
  output logic              dest_valid
);
  localparam int              LEN_OFS = len_lsb(DEST_W);
  localparam logic [DEST_W:0] PORTS   = (DEST_W+1)'(NUM_PORTS);

  logic unused_hdr_bits;

  assign dest            = hdr[DEST_LSB +: DEST_W];
  assign len             = hdr[LEN_OFS +: LEN_W];
  assign dest_valid      = ({1'b0, dest} < PORTS);
  assign unused_hdr_bits = ^hdr;
endmodule

// File: rtl/input_router.sv
// Ingress router: parses headers and steers whole packets to per-port FIFOs; INPUT_ROUTER_STATS_EN adds pkt/drop counters.
// Zero latency (push is combinational from the transfer); backpressure is ack low while the target FIFO is full.
module input_router
  import yas_router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DEST_W    = DEF_DEST_W,
  parameter int LEN_W     = DEF_LEN_W
) (
  input logic                clk,
  input logic                rst,
  input_router_if.slave      bus
`ifdef INPUT_ROUTER_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);
  localparam int DEST_SPAN = 2 ** DEST_W;

  state_e              state_q, state_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [LEN_W-1:0]    remain_q, remain_d;

  logic [DEST_W-1:0]    hdr_dest;
  logic [LEN_W-1:0]     hdr_len;
  logic                 hdr_valid;
  logic [DEST_SPAN-1:0] full_ext;
  logic [DEST_SPAN-1:0] push_ext;
  logic [DEST_W-1:0]    tgt;
  logic                 drop;
  logic                 ack;
  logic                 xfer;

  hdr_decode #(
    .DATA_W    (DATA_W),
    .NUM_PORTS (NUM_PORTS),
    .DEST_W    (DEST_W),
    .LEN_W     (LEN_W)
  ) u_hdr_decode (
    .hdr        (bus.data_in),
    .dest       (hdr_dest),
    .len        (hdr_len),
    .dest_valid (hdr_valid)
  );

  // Pad full flags to the whole dest space so any dest value indexes safely.
  always_comb begin
    full_ext                  = '0;
    full_ext[NUM_PORTS-1:0]   = bus.fifo_full;
  end

  always_comb begin
    tgt  = dest_q;
    drop = 1'b0;
    case (state_q)
      HDR: begin
        tgt  = hdr_dest;
        drop = !hdr_valid;
      end
      PAY:     drop = 1'b0;
      default: drop = 1'b1;
    endcase
    ack = drop | !full_ext[tgt];
  end

  assign xfer = bus.data_in_req & ack;

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    remain_d = remain_q;
    if (xfer) begin
      if (state_q == HDR) begin
        if (hdr_len != '0) begin
          remain_d = hdr_len;
          if (hdr_valid) begin
            dest_d  = hdr_dest;
            state_d = PAY;
          end else begin
            state_d = DROP;
          end
        end
      end else begin
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_W'(1)) state_d = HDR;
      end
    end
  end

  always_comb begin
    push_ext = '0;
    if (xfer && !drop) push_ext[tgt] = 1'b1;
  end

  assign bus.data_in_ack = ack;
  assign bus.fifo_push   = push_ext[NUM_PORTS-1:0];
  assign bus.fifo_data   = bus.data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HDR;
      dest_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      remain_q <= remain_d;
    end
  end

`ifdef INPUT_ROUTER_STATS_EN
  logic [STATS_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [STATS_W-1:0] drop_cnt_q, drop_cnt_d;

  // Only headers count; both counters stick at all-ones.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (xfer && state_q == HDR) begin
      if (hdr_valid && pkt_cnt_q != '1)   pkt_cnt_d  = pkt_cnt_q + 1'b1;
      if (!hdr_valid && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_router.sv
// Directed bench for input_router: a 4-port instance for routing and a 2-port instance for invalid destinations.
module tb_input_router;
  import yas_router_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_router_if #(.DATA_W(8), .NUM_PORTS(4)) b4 ();
  input_router_if #(.DATA_W(8), .NUM_PORTS(2)) b2 ();

`ifdef INPUT_ROUTER_STATS_EN
  logic [15:0] pkt4, drop4, pkt2, drop2;
`endif

  input_router #(.DATA_W(8), .NUM_PORTS(4), .DEST_W(2), .LEN_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (b4)
`ifdef INPUT_ROUTER_STATS_EN
    , .pkt_cnt (pkt4), .drop_cnt (drop4)
`endif
  );

  input_router #(.DATA_W(8), .NUM_PORTS(2), .DEST_W(2), .LEN_W(4)) dut2 (
    .clk (clk), .rst (rst), .bus (b2)
`ifdef INPUT_ROUTER_STATS_EN
    , .pkt_cnt (pkt2), .drop_cnt (drop2)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic drive4(input logic [7:0] d, input logic req, input logic [3:0] full);
    @(negedge clk);
    b4.data_in = d; b4.data_in_req = req; b4.fifo_full = full;
    #1;
  endtask

  task automatic drive2(input logic [7:0] d, input logic req, input logic [1:0] full);
    @(negedge clk);
    b2.data_in = d; b2.data_in_req = req; b2.fifo_full = full;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive4(8'h00, 1'b0, 4'h0);
    drive4(8'h00, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL rst_state: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
    n_chk++; if (dut4.dest_q !== 2'd0) $display("FAIL rst_dest: got %0d want 0", dut4.dest_q); else n_pass++;
    n_chk++; if (dut4.remain_q !== 4'd0) $display("FAIL rst_remain: got %0d want 0", dut4.remain_q); else n_pass++;
    n_chk++; if (b4.fifo_push !== 4'b0000) $display("FAIL rst_push: got %b want 0000", b4.fifo_push); else n_pass++;
    n_chk++; if (b4.data_in_ack !== 1'b1) $display("FAIL rst_ack: got %b want 1", b4.data_in_ack); else n_pass++;
    drive4(8'h01, 1'b0, 4'b0010);
    n_chk++; if (b4.data_in_ack !== 1'b0) $display("FAIL rst_ack_full: got %b want 0", b4.data_in_ack); else n_pass++;
    n_chk++; if (b2.data_in_ack !== 1'b1) $display("FAIL rst_ack2: got %b want 1", b2.data_in_ack); else n_pass++;
`ifdef INPUT_ROUTER_STATS_EN
    n_chk++; if (pkt4 !== 16'd0 || drop4 !== 16'd0) $display("FAIL rst_cnt: got %h/%h want 0/0", pkt4, drop4); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_payload();
    logic [7:0] w [4];
    state_e     st;
    w = '{8'h0D, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) begin
      drive4(w[i], 1'b1, 4'h0);
      st = (i == 0) ? HDR : PAY;
      n_chk++; if (dut4.state_q !== st) $display("FAIL pay_state[%0d]: got %0d want %0d", i, dut4.state_q, st); else n_pass++;
      n_chk++; if (b4.data_in_ack !== 1'b1) $display("FAIL pay_ack[%0d]: got %b want 1", i, b4.data_in_ack); else n_pass++;
      n_chk++; if (b4.fifo_push !== 4'b0010) $display("FAIL pay_push[%0d]: got %b want 0010", i, b4.fifo_push); else n_pass++;
      n_chk++; if (b4.fifo_data !== w[i]) $display("FAIL pay_data[%0d]: got %h want %h", i, b4.fifo_data, w[i]); else n_pass++;
    end
    drive4(8'h00, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL pay_end_state: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
    n_chk++; if (b4.fifo_push !== 4'b0000) $display("FAIL pay_idle_push: got %b want 0000", b4.fifo_push); else n_pass++;
  endtask

  task automatic test_len0();
    drive4(8'h02, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0100) $display("FAIL len0_push: got %b want 0100", b4.fifo_push); else n_pass++;
    drive4(8'h05, 1'b1, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL len0_state: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
    n_chk++; if (b4.fifo_push !== 4'b0010) $display("FAIL len0_next_hdr: got %b want 0010", b4.fifo_push); else n_pass++;
    drive4(8'h33, 1'b0, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0000) $display("FAIL noreq_push: got %b want 0000", b4.fifo_push); else n_pass++;
    drive4(8'h77, 1'b1, 4'h0);
    n_chk++; if (dut4.state_q !== PAY || dut4.remain_q !== 4'd1) $display("FAIL noreq_hold: got %0d/%0d want %0d/1", dut4.state_q, dut4.remain_q, PAY); else n_pass++;
    n_chk++; if (b4.fifo_push !== 4'b0010 || b4.fifo_data !== 8'h77) $display("FAIL len1_pay: got %b/%h want 0010/77", b4.fifo_push, b4.fifo_data); else n_pass++;
    drive4(8'h00, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL len1_end: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
  endtask

  task automatic test_drop();
    drive2(8'h06, 1'b1, 2'b11);
    n_chk++; if (b2.data_in_ack !== 1'b1 || b2.fifo_push !== 2'b00) $display("FAIL drop_hdr: got ack %b push %b want 1/00", b2.data_in_ack, b2.fifo_push); else n_pass++;
    drive2(8'hEE, 1'b1, 2'b11);
    n_chk++; if (dut2.state_q !== DROP) $display("FAIL drop_state: got %0d want %0d", dut2.state_q, DROP); else n_pass++;
    n_chk++; if (b2.data_in_ack !== 1'b1 || b2.fifo_push !== 2'b00) $display("FAIL drop_pay: got ack %b push %b want 1/00", b2.data_in_ack, b2.fifo_push); else n_pass++;
    drive2(8'h00, 1'b0, 2'b00);
    n_chk++; if (dut2.state_q !== HDR) $display("FAIL drop_end: got %0d want %0d", dut2.state_q, HDR); else n_pass++;
`ifdef INPUT_ROUTER_STATS_EN
    n_chk++; if (drop2 !== 16'd1 || pkt2 !== 16'd0) $display("FAIL drop_cnt: got %0d/%0d want 1/0", drop2, pkt2); else n_pass++;
`endif
  endtask

  task automatic test_full();
    drive4(8'h0B, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b1000) $display("FAIL full_hdr: got %b want 1000", b4.fifo_push); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive4(8'hB1, 1'b1, {1'b1, 2'b00, k[0]});
      n_chk++; if (b4.data_in_ack !== 1'b0 || b4.fifo_push !== 4'b0000) $display("FAIL full_stall[%0d]: got ack %b push %b want 0/0000", k, b4.data_in_ack, b4.fifo_push); else n_pass++;
    end
    drive4(8'hB1, 1'b1, 4'b0001);
    n_chk++; if (b4.data_in_ack !== 1'b1 || b4.fifo_push !== 4'b1000 || b4.fifo_data !== 8'hB1) $display("FAIL full_resume: got %b/%b/%h want 1/1000/b1", b4.data_in_ack, b4.fifo_push, b4.fifo_data); else n_pass++;
    drive4(8'hB2, 1'b1, 4'b0000);
    n_chk++; if (b4.fifo_push !== 4'b1000 || b4.fifo_data !== 8'hB2) $display("FAIL full_pay2: got %b/%h want 1000/b2", b4.fifo_push, b4.fifo_data); else n_pass++;
    drive4(8'h00, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL full_end: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive4(8'h10, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0001) $display("FAIL rmid_hdr: got %b want 0001", b4.fifo_push); else n_pass++;
    drive4(8'hC1, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0001) $display("FAIL rmid_pay: got %b want 0001", b4.fifo_push); else n_pass++;
    drive4(8'hC2, 1'b0, 4'h0);
    rst = 1'b1;
    drive4(8'hC2, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR || dut4.remain_q !== 4'd0) $display("FAIL rmid_state: got %0d/%0d want %0d/0", dut4.state_q, dut4.remain_q, HDR); else n_pass++;
    rst = 1'b0;
    drive4(8'h05, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0010) $display("FAIL rmid_newhdr: got %b want 0010", b4.fifo_push); else n_pass++;
    drive4(8'h55, 1'b1, 4'h0);
    n_chk++; if (b4.fifo_push !== 4'b0010) $display("FAIL rmid_newpay: got %b want 0010", b4.fifo_push); else n_pass++;
    drive4(8'h00, 1'b0, 4'h0);
`ifdef INPUT_ROUTER_STATS_EN
    n_chk++; if (pkt4 !== 16'd1) $display("FAIL rmid_cnt: got %0d want 1", pkt4); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [4];
    logic [3:0] p [4];
    w = '{8'h04, 8'hD0, 8'h05, 8'hD1};
    p = '{4'b0001, 4'b0001, 4'b0010, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      drive4(w[i], 1'b1, 4'h0);
      n_chk++; if (b4.data_in_ack !== 1'b1 || b4.fifo_push !== p[i]) $display("FAIL b2b[%0d]: got %b/%b want 1/%b", i, b4.data_in_ack, b4.fifo_push, p[i]); else n_pass++;
    end
    drive4(8'h00, 1'b0, 4'h0);
    n_chk++; if (dut4.state_q !== HDR) $display("FAIL b2b_end: got %0d want %0d", dut4.state_q, HDR); else n_pass++;
`ifdef INPUT_ROUTER_STATS_EN
    n_chk++; if (pkt4 !== 16'd3 || drop4 !== 16'd0) $display("FAIL b2b_cnt: got %0d/%0d want 3/0", pkt4, drop4); else n_pass++;
`endif
  endtask

  initial begin
    b4.data_in = '0; b4.data_in_req = 1'b0; b4.fifo_full = '0;
    b2.data_in = '0; b2.data_in_req = 1'b0; b2.fifo_full = '0;
    test_reset();
    test_payload();
    test_len0();
    test_drop();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
